// File: rtl/buf_pkg.sv
// Shared definitions for the buffer command path (command FIFO and executor).
package buf_pkg;

  // Command word geometry: 8-bit opcode byte over a 32-bit operand word.
  localparam int CMD_W    = 40;
  localparam int CMD_HI_W = 8;
  localparam int CMD_LO_W = 32;

  // Command classes decoded by buf_executor from the opcode byte.
  localparam logic [1:0] WRITE_REG = 2'b01;
  localparam logic [1:0] MISC      = 2'b10;

endpackage

// File: rtl/buf_cmd_ram.sv
// Simple dual-port command RAM: one write port, one registered read port.
// The read register has a synchronous reset so fifo_data comes up as zero,
// which block RAM output registers support directly.
module buf_cmd_ram
  import buf_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CMD_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CMD_W-1:0]  rdata
);

  logic [CMD_W-1:0] mem [2**ADDR_W];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/buf_cmd_fifo.sv
// Command FIFO: assembles 40-bit words from an 8-bit sticky opcode byte and
// 32-bit low-word pushes, and presents buf_executor's one-cycle read port.
module buf_cmd_fifo
  import buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_hi_stb,
  input  logic [CMD_HI_W-1:0] in_hi_data,
  input  logic                in_lo_stb,
  input  logic [CMD_LO_W-1:0] in_lo_data,
  input  logic                flush,
  input  logic                clear_errors,
  output logic                full,
  output logic                overflow,
  output logic                underflow,
  input  logic                fifo_read,
  output logic [CMD_W-1:0]    fifo_data,
  output logic                fifo_empty,
  output logic [31:0]         fifo_local_count
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] ONE_CNT   = (DEPTH_LOG2+1)'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic [CMD_HI_W-1:0]   hi_reg, hi_eff;
  logic                  push_ok, pop_ok, push_err, pop_err;

  // A same-cycle opcode strobe bypasses hi_reg into the pushed word.
  assign hi_eff = in_hi_stb ? in_hi_data : hi_reg;

  // Acceptance uses the registered full/empty only; a pop in a full cycle
  // does not make room for a push. Flush swallows both sides entirely.
  assign push_ok  = in_lo_stb & ~full       & ~flush;
  assign push_err = in_lo_stb &  full       & ~flush;
  assign pop_ok   = fifo_read & ~fifo_empty & ~flush;
  assign pop_err  = fifo_read &  fifo_empty & ~flush;

  // Next occupancy; full/empty/count outputs are registered from it.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   count_nxt = count + ONE_CNT;
        2'b01:   count_nxt = count - ONE_CNT;
        default: count_nxt = count;
      endcase
    end
  end

  // Pointers, occupancy, status and the sticky opcode byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      fifo_empty <= 1'b1;
      hi_reg     <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      count      <= count_nxt;
      full       <= (count_nxt == DEPTH_CNT);
      fifo_empty <= (count_nxt == '0);
      if (in_hi_stb) hi_reg <= in_hi_data;
      // A fresh error outranks a same-cycle clear.
      overflow  <= push_err | (overflow  & ~clear_errors);
      underflow <= pop_err  | (underflow & ~clear_errors);
    end
  end

  assign fifo_local_count = 32'(count);

  buf_cmd_ram #(.ADDR_W(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata ({hi_eff, in_lo_data}),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (fifo_data)
  );

endmodule
